seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor of the single-cycle execute ALU.
- Handles the base integer, shift, compare, branch and jump ops, plus the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Base ops use a fixed 1-cycle latency; mul/div use a multi-cycle iterative datapath.
- Sits in the execute stage behind a valid/ready handshake so decode can stall on long ops.

Parameters:
- XLEN, 32, operand/result width (power of two, >=8).
- SHAMT_W, $clog2(XLEN), number of operand_B bits used as shift amount.
- CTRL_W, 6, width of ALU_Control.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of in-flight op.
- in_valid  in  1  op presented.
- in_ready  out  1  op accepted when in_valid&in_ready.
- ALU_Control  in  CTRL_W  [5]=M-ext, [4:3]=group, [2:0]=funct3.
- operand_A  in  XLEN  first operand (PC+4 for jumps).
- operand_B  in  XLEN  second operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- ALU_result  out  XLEN  registered result.
- branch  out  1  registered branch-taken flag.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (async, active-high): state=IDLE; out_valid=0, ALU_result=0, branch=0, busy=0, in_ready=1.
- States:
  - IDLE: no op held.
  - ITER: mul/div iterating.
  - DONE: result held.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Base ops (bit5=0), encodings:
  - Group 00: add/sll/slt/sltu/xor/srl/or/and.
  - Group 01: funct3 000=sub, 101=sra, other funct3 -> result 0.
  - Group 10: beq/bne/blt/bge/bltu/bgeu. branch = compare result; ALU_result = {0, branch}. funct3 010/011 -> branch=0.
  - Group 11: ALU_result = operand_A, branch=1.
- Base-op timing: accepted -> DONE next cycle, 1-cycle latency.
- Shifts use operand_B[SHAMT_W-1:0] only. Arithmetic left shift equals logical shift.
- branch=0 for all non-group-10/11 ops, including all M-ext ops.
- M-ext (bit5=1, funct3 000..111 = MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU):
  - Operands are latched on accept; busy=1.
  - Multiply: radix-2 shift-add on magnitudes, XLEN iterations, sign fixup in final cycle. Acceptance to out_valid = XLEN+1 cycles.
  - Divide: restoring, XLEN iterations on magnitudes, quotient sign = sA^sB, remainder sign = sA. Latency XLEN+1.
  - Divide-by-zero: quotient = all ones, remainder = operand_A. Resolved in 1 cycle with no iteration.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1), remainder = 0, 1-cycle latency.
- DONE: out_valid=1; ALU_result/branch held stable until out_ready.
  - out_ready & !in_valid -> IDLE.
  - out_ready & in_valid -> new op accepted same cycle (back-to-back).
- flush: highest priority after reset.
  - Next cycle: state=IDLE, out_valid=0, busy=0.
  - An op presented in the flush cycle is not accepted (in_ready forced 0).
- Reset mid-ITER: aborts immediately; no result is produced.

Optional Feature:
- SEQ_ALU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single combinational 2*XLEN product and complete in 1 cycle like base ops.
- Undefined: iterative multiplier as above.
- Divide is always iterative.
- Results are bit-identical in both builds; only latency differs.

Decomposition:
- Shared package seq_alu_pkg holds:
  - funct3 localparams (ALU, branch, M-ext).
  - Group codes 2'b00..2'b11.
  - State enum {IDLE, ITER, DONE}.
  - Divide special-case constants.
- One sub-module: seq_alu_muldiv (iterative mul/div engine with start/done handshake, sign pre/post-processing, counter of SHAMT_W+1 bits).
- Top holds the FSM, base-op combinational logic and output registers.

Test Plan:
- ADD 0x7FFFFFFF + 1, out_ready=1 -> out_valid one cycle after accept, ALU_result=0x80000000, branch=0.
- SRA 0x80000000 by operand_B=0x21 -> uses shamt 1, ALU_result=0xC0000000. BLTU 1 vs 0xFFFFFFFF -> branch=1, ALU_result=1.
- MULH 0xFFFFFFFF * 0xFFFFFFFF -> 0. MULHU same operands -> 0xFFFFFFFE. Each result arrives 33 cycles after accept with busy=1 throughout (1 cycle with SEQ_ALU_FAST_MUL_EN).
- DIV 7 / 0 -> 0xFFFFFFFF, REM 7 / 0 -> 7. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0. Each in 1 cycle. DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
- Hold out_ready=0 for 5 cycles after a result -> ALU_result stable, in_ready=0. Then out_ready=1 with in_valid=1 -> back-to-back accept in the same cycle.
- Assert flush and, separately, reset at iteration 10 of a DIVU -> out_valid never rises for it, busy=0 next cycle, a following ADD completes normally.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: op groups, funct3 codes,
// FSM states and divide special-case fill values.
package seq_alu_pkg;

  localparam logic [1:0] GRP_ALU = 2'b00;
  localparam logic [1:0] GRP_ALT = 2'b01;
  localparam logic [1:0] GRP_BR  = 2'b10;
  localparam logic [1:0] GRP_JMP = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_SUB  = 3'b000;
  localparam logic [2:0] F3_SRA  = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  localparam logic DIVZ_Q_FILL = 1'b1;
  localparam logic OVF_Q_MSB   = 1'b1;
  localparam logic OVF_R_FILL  = 1'b0;

  function automatic logic a_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide on operand
// magnitudes; the last step and sign fixup are combinational.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            kill,
  input  logic            start,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [SHAMT_W:0] LAST = (SHAMT_W+1)'(XLEN-1);
  localparam logic [SHAMT_W:0] ONE  = (SHAMT_W+1)'(1);

  logic             run;
  logic [SHAMT_W:0] cnt;
  logic [2:0]       op;
  logic             sa, sb;
  logic [XLEN-1:0]  mb, hi, lo;
  logic [XLEN-1:0]  hi_n, lo_n;
  logic             sa_in, sb_in;
  logic [XLEN-1:0]  ma_in, mb_in;
  logic [XLEN:0]    sum, rsh, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]  quo, rem;

  assign sa_in = a_signed(f3) & a[XLEN-1];
  assign sb_in = b_signed(f3) & b[XLEN-1];
  assign ma_in = sa_in ? -a : a;
  assign mb_in = sb_in ? -b : b;

  always_comb begin
    sum  = {1'b0, hi} + {1'b0, (lo[0] ? mb : {XLEN{1'b0}})};
    rsh  = {hi, lo[XLEN-1]};
    diff = rsh - {1'b0, mb};
    if (op[2]) begin
      hi_n = diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      {hi_n, lo_n} = {sum, lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = {hi_n, lo_n};
    if (sa ^ sb) prod = -prod;
    quo = (sa ^ sb) ? -lo_n : lo_n;
    rem = sa ? -hi_n : hi_n;
    if (op[2])
      result = op[1] ? rem : quo;
    else if (op == F3_MUL)
      result = prod[XLEN-1:0];
    else
      result = prod[2*XLEN-1:XLEN];
  end

  assign done = run & (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
      op  <= '0;
      sa  <= 1'b0;
      sb  <= 1'b0;
      mb  <= '0;
      hi  <= '0;
      lo  <= '0;
    end else if (kill) begin
      run <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      op  <= f3;
      sa  <= sa_in;
      sb  <= sb_in;
      hi  <= '0;
      // divide shifts the dividend out of lo; multiply adds |a|
      if (f3[2]) begin
        lo <= ma_in;
        mb <= mb_in;
      end else begin
        lo <= mb_in;
        mb <= ma_in;
      end
    end else if (run) begin
      if (done) begin
        run <= 1'b0;
      end else begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered execute ALU with iterative M-extension engine.
// Define SEQ_ALU_FAST_MUL_EN for a single-cycle multiplier.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int CTRL_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ALU_Control,
  input  logic [XLEN-1:0]   operand_A,
  input  logic [XLEN-1:0]   operand_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   ALU_result,
  output logic              branch,
  output logic              busy
);

  localparam logic [XLEN-1:0] MIN_INT =
    {OVF_Q_MSB, {(XLEN-1){1'b0}}};

  state_t state, state_n;

  logic               is_m;
  logic [1:0]         grp;
  logic [2:0]         f3;
  logic [SHAMT_W-1:0] sh;
  logic               eq, lt, ltu;
  logic [XLEN-1:0]    base_res;
  logic               base_br;
  logic               div_zero, div_ovf, div_spec;
  logic [XLEN-1:0]    spec_res;
  logic               fast_mul;
  logic [XLEN-1:0]    fmul_res;
  logic               quick;
  logic [XLEN-1:0]    quick_res;
  logic               quick_br;
  logic               accept, start;
  logic               load_q, load_e;
  logic               eng_done;
  logic [XLEN-1:0]    eng_res;

  assign is_m = ALU_Control[5];
  assign grp  = ALU_Control[4:3];
  assign f3   = ALU_Control[2:0];
  assign sh   = operand_B[SHAMT_W-1:0];

  always_comb begin
    eq  = operand_A == operand_B;
    lt  = $signed(operand_A) < $signed(operand_B);
    ltu = operand_A < operand_B;
    base_res = '0;
    base_br  = 1'b0;
    unique case (grp)
      GRP_ALU: begin
        unique case (f3)
          F3_ADD:  base_res = operand_A + operand_B;
          F3_SLL:  base_res = operand_A << sh;
          F3_SLT:  base_res = {{(XLEN-1){1'b0}}, lt};
          F3_SLTU: base_res = {{(XLEN-1){1'b0}}, ltu};
          F3_XOR:  base_res = operand_A ^ operand_B;
          F3_SRL:  base_res = operand_A >> sh;
          F3_OR:   base_res = operand_A | operand_B;
          F3_AND:  base_res = operand_A & operand_B;
        endcase
      end
      GRP_ALT: begin
        if (f3 == F3_SUB)
          base_res = operand_A - operand_B;
        else if (f3 == F3_SRA)
          base_res = $signed(operand_A) >>> sh;
      end
      GRP_BR: begin
        case (f3)
          F3_BEQ:  base_br = eq;
          F3_BNE:  base_br = ~eq;
          F3_BLT:  base_br = lt;
          F3_BGE:  base_br = ~lt;
          F3_BLTU: base_br = ltu;
          F3_BGEU: base_br = ~ltu;
          default: base_br = 1'b0;
        endcase
        base_res = {{(XLEN-1){1'b0}}, base_br};
      end
      GRP_JMP: begin
        base_res = operand_A;
        base_br  = 1'b1;
      end
    endcase
  end

  assign div_zero = operand_B == '0;
  assign div_ovf  = ~f3[0] & (operand_A == MIN_INT) & (&operand_B);
  assign div_spec = is_m & f3[2] & (div_zero | div_ovf);
  assign spec_res = div_zero
    ? (f3[1] ? operand_A : {XLEN{DIVZ_Q_FILL}})
    : (f3[1] ? {XLEN{OVF_R_FILL}} : MIN_INT);

`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fp;
  assign fa = {{XLEN{a_signed(f3) & operand_A[XLEN-1]}}, operand_A};
  assign fb = {{XLEN{b_signed(f3) & operand_B[XLEN-1]}}, operand_B};
  assign fp = fa * fb;
  assign fast_mul = is_m & ~f3[2];
  assign fmul_res = (f3 == F3_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
  assign fast_mul = 1'b0;
  assign fmul_res = '0;
`endif

  assign quick = ~is_m | div_spec | fast_mul;

  always_comb begin
    quick_res = base_res;
    quick_br  = 1'b0;
    unique case (1'b1)
      ~is_m:    quick_br  = base_br;
      div_spec: quick_res = spec_res;
      fast_mul: quick_res = fmul_res;
      default: ;
    endcase
  end

  assign in_ready  = ~flush & ((state == IDLE) |
                     ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign start     = accept & ~quick;
  assign out_valid = state == DONE;
  assign busy      = state == ITER;

  seq_alu_muldiv #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .kill   (flush),
    .start  (start),
    .f3     (f3),
    .a      (operand_A),
    .b      (operand_B),
    .done   (eng_done),
    .result (eng_res)
  );

  always_comb begin
    state_n = state;
    load_q  = 1'b0;
    load_e  = 1'b0;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state_n = quick ? DONE : ITER;
            load_q  = quick;
          end else if (state == DONE && out_ready) begin
            state_n = IDLE;
          end
        end
        ITER: begin
          if (eng_done) begin
            state_n = DONE;
            load_e  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ALU_result <= '0;
      branch     <= 1'b0;
    end else begin
      state <= state_n;
      if (load_q) begin
        ALU_result <= quick_res;
        branch     <= quick_br;
      end else if (load_e) begin
        ALU_result <= eng_res;
        branch     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: base ops, M-ext, divide special
// cases, output hold, back-to-back accept, flush and reset abort.
module tb_seq_alu;

`ifdef SEQ_ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [5:0] C_ADD    = 6'b000_000;
  localparam logic [5:0] C_SLL    = 6'b000_001;
  localparam logic [5:0] C_SLT    = 6'b000_010;
  localparam logic [5:0] C_SUB    = 6'b001_000;
  localparam logic [5:0] C_SRA    = 6'b001_101;
  localparam logic [5:0] C_ALT_X  = 6'b001_011;
  localparam logic [5:0] C_BEQ    = 6'b010_000;
  localparam logic [5:0] C_BLTU   = 6'b010_110;
  localparam logic [5:0] C_BR_X   = 6'b010_010;
  localparam logic [5:0] C_JAL    = 6'b011_000;
  localparam logic [5:0] C_MUL    = 6'b100_000;
  localparam logic [5:0] C_MULH   = 6'b100_001;
  localparam logic [5:0] C_MULHSU = 6'b100_010;
  localparam logic [5:0] C_MULHU  = 6'b100_011;
  localparam logic [5:0] C_DIV    = 6'b100_100;
  localparam logic [5:0] C_DIVU   = 6'b100_101;
  localparam logic [5:0] C_REM    = 6'b100_110;
  localparam logic [5:0] C_REMU   = 6'b100_111;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_result;
  logic        branch;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALU_Control (ALU_Control),
    .operand_A   (operand_A),
    .operand_B   (operand_B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALU_result  (ALU_result),
    .branch      (branch),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eb,
                        input int elat);
    int lat;
    bit busy_ok;
    @(negedge clock);
    ALU_Control = ctrl;
    operand_A   = a;
    operand_B   = b;
    in_valid    = 1'b1;
    #1 chk({tag, "/rdy"}, {31'b0, in_ready}, 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clock);
      #1 lat++;
    end
    chk({tag, "/lat"}, lat, elat);
    chk({tag, "/res"}, ALU_result, er);
    chk({tag, "/br"}, {31'b0, branch}, {31'b0, eb});
    if (elat > 1) chk({tag, "/busy"}, {31'b0, busy_ok}, 32'd1);
  endtask

  task automatic abort_test(input string tag, input bit use_reset);
    bit seen;
    @(negedge clock);
    ALU_Control = C_DIVU;
    operand_A   = 32'h0000_1000;
    operand_B   = 32'd3;
    in_valid    = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    chk({tag, "/busy_on"}, {31'b0, busy}, 32'd1);
    chk({tag, "/rdy_iter"}, {31'b0, in_ready}, 32'd0);
    repeat (9) @(posedge clock);
    @(negedge clock);
    if (use_reset) begin
      reset = 1'b1;
    end else begin
      flush       = 1'b1;
      ALU_Control = C_ADD;
      operand_A   = 32'd1;
      operand_B   = 32'd1;
      in_valid    = 1'b1;
      #1 chk({tag, "/rdy_flush"}, {31'b0, in_ready}, 32'd0);
    end
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk({tag, "/busy_off"}, {31'b0, busy}, 32'd0);
    chk({tag, "/ov_off"}, {31'b0, out_valid}, 32'd0);
    if (use_reset) begin
      chk({tag, "/res_clr"}, ALU_result, 32'd0);
      @(negedge clock);
      reset = 1'b0;
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1 if (out_valid) seen = 1'b1;
    end
    chk({tag, "/no_result"}, {31'b0, seen}, 32'd0);
    run_op({tag, "/add_after"}, C_ADD, 32'd40, 32'd2, 32'd42, 1'b0, 1);
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    ALU_Control = '0;
    operand_A   = '0;
    operand_B   = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst/out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst/result", ALU_result, 32'd0);
    chk("rst/branch", {31'b0, branch}, 32'd0);
    chk("rst/busy", {31'b0, busy}, 32'd0);
    chk("rst/in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b0;

    run_op("add", C_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);
    run_op("sra", C_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1);
    run_op("sll", C_SLL, 32'd1, 32'h24, 32'h10, 1'b0, 1);
    run_op("slt", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    run_op("sub", C_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("alt_x", C_ALT_X, 32'd5, 32'd7, 32'd0, 1'b0, 1);
    run_op("bltu", C_BLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1);
    run_op("beq_n", C_BEQ, 32'd3, 32'd4, 32'd0, 1'b0, 1);
    run_op("br_x", C_BR_X, 32'd1, 32'd2, 32'd0, 1'b0, 1);
    run_op("jal", C_JAL, 32'h0000_0104, 32'd9, 32'h0000_0104, 1'b1, 1);

    run_op("mulh", C_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0,
           MUL_LAT);
    run_op("mulhu", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 1'b0, MUL_LAT);
    run_op("mul", C_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0,
           MUL_LAT);
    run_op("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
           1'b0, MUL_LAT);

    run_op("div_z", C_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("rem_z", C_REM, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    run_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b0, 1);
    run_op("rem_ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
           1'b0, 1);
    run_op("div_n", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0,
           DIV_LAT);
    run_op("rem_n", C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0,
           DIV_LAT);
    run_op("div_nb", C_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0,
           DIV_LAT);
    run_op("rem_nb", C_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 1'b0, DIV_LAT);
    run_op("divu", C_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, DIV_LAT);
    run_op("remu", C_REMU, 32'd100, 32'd7, 32'd2, 1'b0, DIV_LAT);

    @(posedge clock);
    #1 out_ready = 1'b0;
    run_op("hold", C_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1);
    repeat (5) begin
      @(posedge clock);
      #1;
      chk("hold/res", ALU_result, 32'd3);
      chk("hold/valid", {31'b0, out_valid}, 32'd1);
      chk("hold/rdy", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clock);
    ALU_Control = C_ADD;
    operand_A   = 32'd10;
    operand_B   = 32'd20;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    #1 chk("b2b/rdy", {31'b0, in_ready}, 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    chk("b2b/valid", {31'b0, out_valid}, 32'd1);
    chk("b2b/res", ALU_result, 32'd30);

    abort_test("flush", 1'b0);
    abort_test("reset", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
